// File: rtl/wolfram_ca_pkg.sv
// Shared types and constants for the elementary-CA sequencer.
package wolfram_ca_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StEval   = 2'd1,
    StCommit = 2'd2,
    StOutput = 2'd3
  } ca_state_e;

  // Edge-neighbour handling: wrap around or read out-of-range cells as 0.
  localparam int unsigned BOUNDARY_WRAP = 0;
  localparam int unsigned BOUNDARY_NULL = 1;

  // Default rule truth table.
  localparam logic [7:0] RULE_DEFAULT = 8'h99;

endpackage

// File: rtl/wolfram_rule_cell.sv
// Combinational elementary-CA rule lookup: out = RULE[{in1,in2,in3}].
module wolfram_rule_cell
  import wolfram_ca_pkg::*;
#(
  parameter logic [7:0] RULE = RULE_DEFAULT
) (
  input  logic i_in1,
  input  logic i_in2,
  input  logic i_in3,
  output logic o_out
);

  logic [2:0] w_sel;

  // Truth-table lookup indexed by the three neighbour bits.
  always_comb begin
    w_sel = {i_in1, i_in2, i_in3};
    o_out = RULE[w_sel];
  end

endmodule

// File: rtl/wolfram_ca_sequencer.sv
// Time-multiplexed elementary-CA sequencer: evaluates one cell per cycle through a
// single shared rule LUT, commits whole generations and streams out the final state.
module wolfram_ca_sequencer
  import wolfram_ca_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter logic [7:0]  RULE     = RULE_DEFAULT,
  parameter int unsigned GEN_W    = 8,
  parameter int unsigned BOUNDARY = BOUNDARY_WRAP
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_start,
  input  logic [GEN_W-1:0] i_num_gens,
  input  logic             i_abort,
  output logic             o_busy,
  output logic [GEN_W-1:0] o_gen_count,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_out_data
);

  localparam int unsigned      IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [GEN_W-1:0] GEN_ONE  = GEN_W'(1);

  ca_state_e        r_fsm,       w_fsm_nxt;
  logic [WIDTH-1:0] r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_shadow,    w_shadow_nxt;
  logic [IDX_W-1:0] r_idx,       w_idx_nxt;
  logic [GEN_W-1:0] r_gen_count, w_gen_nxt;
  logic [GEN_W-1:0] r_num_gens,  w_num_nxt;

  logic [IDX_W-1:0] w_idx_up;
  logic [IDX_W-1:0] w_idx_dn;
  logic             w_in1;
  logic             w_in2;
  logic             w_in3;
  logic             w_rule_out;
  logic [GEN_W-1:0] w_gen_inc;

  // Neighbour mux: left/right cells of the current index, from the committed state.
  always_comb begin
    w_idx_up = (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
    w_idx_dn = (r_idx == '0) ? IDX_LAST : r_idx - IDX_W'(1);
    w_in2    = r_state[r_idx];
    if (BOUNDARY == BOUNDARY_NULL && r_idx == IDX_LAST) begin
      w_in1 = 1'b0;
    end else begin
      w_in1 = r_state[w_idx_up];
    end
    if (BOUNDARY == BOUNDARY_NULL && r_idx == '0) begin
      w_in3 = 1'b0;
    end else begin
      w_in3 = r_state[w_idx_dn];
    end
  end

  wolfram_rule_cell #(
    .RULE (RULE)
  ) u_rule_cell (
    .i_in1 (w_in1),
    .i_in2 (w_in2),
    .i_in3 (w_in3),
    .o_out (w_rule_out)
  );

  // Next-state and datapath update for the sequencer FSM.
  always_comb begin
    w_fsm_nxt    = r_fsm;
    w_state_nxt  = r_state;
    w_shadow_nxt = r_shadow;
    w_idx_nxt    = r_idx;
    w_gen_nxt    = r_gen_count;
    w_num_nxt    = r_num_gens;
    w_gen_inc    = r_gen_count + GEN_ONE;
    unique case (r_fsm)
      StIdle: begin
        // A load in the same cycle as start takes priority and suppresses the run.
        if (i_load_valid) begin
          w_state_nxt = i_load_data;
        end else if (i_start) begin
          w_num_nxt = i_num_gens;
          w_gen_nxt = '0;
          w_idx_nxt = '0;
          w_fsm_nxt = (i_num_gens != '0) ? StEval : StOutput;
        end
      end
      StEval: begin
        if (i_abort) begin
          w_idx_nxt = '0;
          w_fsm_nxt = StIdle;
        end else begin
          w_shadow_nxt[r_idx] = w_rule_out;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt = '0;
            w_fsm_nxt = StCommit;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      StCommit: begin
        w_idx_nxt = '0;
        if (i_abort) begin
          w_fsm_nxt = StIdle;
        end else begin
          w_state_nxt = r_shadow;
          w_gen_nxt   = w_gen_inc;
          w_fsm_nxt   = (w_gen_inc == r_num_gens) ? StOutput : StEval;
        end
      end
      StOutput: begin
        if (i_out_ready) begin
          w_fsm_nxt = StIdle;
        end
      end
      default: begin
        w_fsm_nxt = StIdle;
      end
    endcase
  end

  // State, shadow and counter registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fsm       <= StIdle;
      r_state     <= '0;
      r_shadow    <= '0;
      r_idx       <= '0;
      r_gen_count <= '0;
      r_num_gens  <= '0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_state     <= w_state_nxt;
      r_shadow    <= w_shadow_nxt;
      r_idx       <= w_idx_nxt;
      r_gen_count <= w_gen_nxt;
      r_num_gens  <= w_num_nxt;
    end
  end

  // Status and output decode.
  always_comb begin
    o_load_ready = (r_fsm == StIdle);
    o_busy       = (r_fsm != StIdle);
    o_out_valid  = (r_fsm == StOutput);
    o_out_data   = r_state;
    o_gen_count  = r_gen_count;
  end

endmodule
